sprite_line_scanner: RTL and testbench
======================================

# sprite_line_scanner

Parametrised per-scanline sprite front end for the sprite pipeline. On each `start_row` it scans the sprite attribute RAM for sprites intersecting `next_vcount` and queues hits in a ring FIFO of depth `MAX_SLOT`. It presents queued hits to the sprite drawer over a valid/ready handshake. Compared with the previous front end it adds configurable sprite height, a registered-read RAM pipeline, full-with-pop enqueue, per-row overflow reporting and optional vertical flip.

## Interface
- `NUM_SPRITE`, 32, attribute entries scanned per row (power of 2, ≥2).
- `MAX_SLOT`, 8, FIFO depth (power of 2, ≥2).
- `SPRITE_H`, 16, sprite height in lines (power of 2, 2..64); `ROWW = $clog2(SPRITE_H)`.
- `V_ACTIVE`, 480, visible lines; rows with `next_vcount >= V_ACTIVE` are blank.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start_row`  in  1  one-cycle pulse that begins a new row.
- `next_vcount`  in  10  row being prepared; stable from `start_row` until `fe_done`.
- `ra`  out  `$clog2(NUM_SPRITE)`  attribute RAM read address.
- `rd_data`  in  32  attribute word; valid one cycle after `ra`.
  - [31] enable, [30] hflip, [29] vflip, [26:18] y, [17:8] x, [7:0] frame.
- `draw_valid`  out  1  a hit is presented.
- `draw_ready`  in  1  drawer accepts the hit.
- `draw_idle`  in  1  drawer has no work in flight.
- `col_base`  out  10  sprite x.
- `hflip`  out  1  horizontal flip.
- `frame_id`  out  8  sprite frame.
- `row_off`  out  ROWW  line within the sprite.
- `row_overflow`  out  1  sticky for the current row: at least one hit was dropped.
- `drop_count`  out  8  hits dropped this row; saturates at 255.
- `fe_done`  out  1  row complete, or row is blank.

## Operation
- Reset values: `ra`=0, `draw_valid`=0, `col_base`=0, `hflip`=0, `frame_id`=0, `row_off`=0, `row_overflow`=0, `drop_count`=0, `fe_done`=1. FIFO is empty and the state is IDLE.
- States: IDLE, SCAN, DRAIN.
- `start_row`, in any state including mid-row, does the following:
  - flushes the FIFO, clears `draw_valid`, `row_overflow` and `drop_count`;
  - on a visible row: sets `ra`=0, enters SCAN, sets `fe_done`=0;
  - on a blank row: stays in IDLE with `fe_done`=1.
- SCAN:
  - `ra` increments every cycle up to `NUM_SPRITE-1`.
  - One cycle after each address, `rd_data` is evaluated for that index.
  - After index `NUM_SPRITE-1` has been evaluated, the state moves to DRAIN.
- Hit test, in 10-bit arithmetic:
  - `y10` = zero-extended y; `delta` = `next_vcount - y10`.
  - hit = enable && `next_vcount >= y10` && `delta < SPRITE_H`.
  - `row_off` = `delta[ROWW-1:0]`, or its vertical-flip form (see Configuration).
- Enqueue: on a hit, if `cnt < MAX_SLOT`, or if a pop occurs in the same cycle, the entry is written at `tail`.
  - Otherwise the hit is dropped: `row_overflow` is set and `drop_count` increments (saturating).
- Output register:
  - Loads from the FIFO head when `!draw_valid || draw_ready` and the FIFO is non-empty.
  - Otherwise `draw_valid` falls on acceptance.
  - Fields hold their values while `draw_valid && !draw_ready`.
- Push and pop in the same cycle leave `cnt` unchanged. Pointers wrap modulo `MAX_SLOT`.
- DRAIN → IDLE with `fe_done`=1 when the FIFO is empty, `draw_valid`=0 and `draw_idle`=1.
- Sprites are emitted in ascending index order.

## Timing
- `start_row` in cycle T:
  - `ra`=k in cycle T+1+k;
  - hit for index k is evaluated in T+2+k and visible in the FIFO in T+3+k;
  - earliest `draw_valid` for that hit is T+4+k.
- Maximum throughput is one hit per cycle.
- An all-miss visible row with `draw_idle`=1 raises `fe_done` in cycle T+NUM_SPRITE+3.
- A blank row raises `fe_done` in T+1.
- An asynchronous `reset` mid-row returns all outputs to their reset values immediately.

## Configuration
- `SPRITE_VFLIP_EN` defined:
  - a hit with bit 29 set gives `row_off` = `SPRITE_H-1-delta[ROWW-1:0]`.
- Not defined:
  - bit 29 is ignored and `row_off` = `delta[ROWW-1:0]`.

## Test plan
- Sprite 5: en=1, y=100, x=200, frame=7, hflip=1; `next_vcount`=103, `draw_ready`=1.
  - → exactly one transfer: `col_base`=200, `frame_id`=7, `hflip`=1, `row_off`=3.
  - → `fe_done` rises once the drawer is idle.
- Boundaries: y=100 with `next_vcount`=99, 100, 115, 116.
  - → hit only at 100 (`row_off`=0) and 115 (`row_off`=15).
- All 32 sprites enabled at y=0, `next_vcount`=0, `draw_ready`=0.
  - → 8 queued, `row_overflow`=1, `drop_count`=23.
  - Holding `draw_valid` also takes an entry out of the FIFO: 9 hits are captured (8 in the FIFO plus the held output register), so 32 − 9 = 23 are dropped.
- Random `draw_ready` backpressure with 8 hits.
  - → ascending index order, no duplicates, fields stable while stalled.
- `start_row` mid-DRAIN with `next_vcount`=480.
  - → `draw_valid`=0 next cycle, FIFO empty, `fe_done`=1.
- `SPRITE_VFLIP_EN` with vflip=1 and `delta`=3 → `row_off`=12; without the macro → `row_off`=3.

Source files
------------

// File: rtl/sprite_line_scanner.sv
// Per-scanline sprite front end: scans attribute RAM, queues hits in a ring FIFO, hands them to the drawer.
// Optional vertical flip of row_off is enabled by defining SPRITE_VFLIP_EN.
module sprite_line_scanner #(
   parameter int NUM_SPRITE = 32,
   parameter int MAX_SLOT   = 8,
   parameter int SPRITE_H   = 16,
   parameter int V_ACTIVE   = 480
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start_row,
   input  logic [9:0]                    next_vcount,
   output logic [$clog2(NUM_SPRITE)-1:0] ra,
   input  logic [31:0]                   rd_data,
   output logic                          draw_valid,
   input  logic                          draw_ready,
   input  logic                          draw_idle,
   output logic [9:0]                    col_base,
   output logic                          hflip,
   output logic [7:0]                    frame_id,
   output logic [$clog2(SPRITE_H)-1:0]   row_off,
   output logic                          row_overflow,
   output logic [7:0]                    drop_count,
   output logic                          fe_done
);

   localparam int ROWW = $clog2(SPRITE_H);
   localparam int AW   = $clog2(NUM_SPRITE);
   localparam int PW   = $clog2(MAX_SLOT);
   localparam int CW   = PW + 1;

   localparam logic [AW-1:0]   RA_LAST = AW'(NUM_SPRITE - 1);
   localparam logic [CW-1:0]   FULL    = CW'(MAX_SLOT);
   localparam logic [9:0]      H10     = 10'(SPRITE_H);
   localparam logic [10:0]     V_ACT   = 11'(V_ACTIVE);
`ifdef SPRITE_VFLIP_EN
   localparam logic [ROWW-1:0] ROW_MAX = ROWW'(SPRITE_H - 1);
`endif

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

   typedef struct packed {
      logic [9:0]      col;
      logic            hflip;
      logic [7:0]      frame;
      logic [ROWW-1:0] row_off;
   } hit_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   ra_q, ra_d;
   logic            issue_q, issue_d;
   logic            pend_q, pend_d;
   logic            pend_last_q, pend_last_d;
   logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   hit_t            out_q, out_d;
   logic            dv_q, dv_d;
   logic            ovf_q, ovf_d;
   logic [7:0]      drop_q, drop_d;
   logic            fe_q, fe_d;

   hit_t            fifo_mem [MAX_SLOT];
   hit_t            new_hit;
   logic [9:0]      y10, delta;
   logic [ROWW-1:0] roff;
   logic            hit, push, pop, drop;
   logic            unused_bits;

`ifdef SPRITE_VFLIP_EN
   assign unused_bits = ^rd_data[28:27];
`else
   assign unused_bits = ^rd_data[29:27];
`endif

   // Hit test for the word read back from the address issued last cycle.
   always_comb begin
      y10   = {1'b0, rd_data[26:18]};
      delta = next_vcount - y10;
      hit   = pend_q && rd_data[31] && (next_vcount >= y10) && (delta < H10);
`ifdef SPRITE_VFLIP_EN
      roff  = rd_data[29] ? (ROW_MAX - delta[ROWW-1:0]) : delta[ROWW-1:0];
`else
      roff  = delta[ROWW-1:0];
`endif
      new_hit = '{col: rd_data[17:8], hflip: rd_data[30], frame: rd_data[7:0], row_off: roff};
      pop   = !start_row && (!dv_q || draw_ready) && (cnt_q != '0);
      push  = !start_row && hit && ((cnt_q != FULL) || pop);
      drop  = !start_row && hit && !push;
   end

   always_comb begin
      // NOTE: every next-state variable takes its held value first so no path leaves it unassigned (no latches).
      state_d     = state_q;
      ra_d        = ra_q;
      issue_d     = issue_q;
      pend_d      = pend_q;
      pend_last_d = pend_last_q;
      head_d      = head_q;
      tail_d      = tail_q;
      cnt_d       = cnt_q;
      out_d       = out_q;
      dv_d        = dv_q;
      ovf_d       = ovf_q;
      drop_d      = drop_q;
      fe_d        = fe_q;

      if (start_row) begin
         head_d      = '0;
         tail_d      = '0;
         cnt_d       = '0;
         dv_d        = 1'b0;
         ovf_d       = 1'b0;
         drop_d      = '0;
         pend_d      = 1'b0;
         pend_last_d = 1'b0;
         issue_d     = 1'b0;
         if ({1'b0, next_vcount} < V_ACT) begin
            state_d = SCAN;
            ra_d    = '0;
            issue_d = 1'b1;
            fe_d    = 1'b0;
         end else begin
            state_d = IDLE;
            fe_d    = 1'b1;
         end
      end else begin
         pend_d      = issue_q;
         pend_last_d = issue_q && (ra_q == RA_LAST);
         if (issue_q) begin
            if (ra_q == RA_LAST) issue_d = 1'b0;
            else                 ra_d    = ra_q + 1'b1;
         end
         if (pend_q && pend_last_q) state_d = DRAIN;

         if (push) tail_d = tail_q + 1'b1;
         if (pop)  head_d = head_q + 1'b1;
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase

         if (pop) begin
            out_d = fifo_mem[head_q];
            dv_d  = 1'b1;
         end else if (draw_ready) begin
            dv_d  = 1'b0;
         end

         if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != 8'hFF) drop_d = drop_q + 1'b1;
         end

         if (state_q == DRAIN && cnt_q == '0 && !dv_q && draw_idle) begin
            state_d = IDLE;
            fe_d    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         ra_q        <= '0;
         issue_q     <= 1'b0;
         pend_q      <= 1'b0;
         pend_last_q <= 1'b0;
         head_q      <= '0;
         tail_q      <= '0;
         cnt_q       <= '0;
         out_q       <= '0;
         dv_q        <= 1'b0;
         ovf_q       <= 1'b0;
         drop_q      <= '0;
         fe_q        <= 1'b1;
      end else begin
         state_q     <= state_d;
         ra_q        <= ra_d;
         issue_q     <= issue_d;
         pend_q      <= pend_d;
         pend_last_q <= pend_last_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         dv_q        <= dv_d;
         ovf_q       <= ovf_d;
         drop_q      <= drop_d;
         fe_q        <= fe_d;
      end
   end

   // NOTE: FIFO storage has no reset; cnt_q/head_q gate every read, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[tail_q] <= new_hit;
   end

   assign ra           = ra_q;
   assign draw_valid   = dv_q;
   assign col_base     = out_q.col;
   assign hflip        = out_q.hflip;
   assign frame_id     = out_q.frame;
   assign row_off      = out_q.row_off;
   assign row_overflow = ovf_q;
   assign drop_count   = drop_q;
   assign fe_done      = fe_q;

endmodule

// File: tb/tb_sprite_line_scanner.sv
// Scoreboard bench for sprite_line_scanner: a row-level model queues expected hits, a monitor checks transfers.
module tb_sprite_line_scanner;

   localparam int NUM  = 32;
   localparam int H    = 16;
   localparam int VACT = 480;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_row;
   logic [9:0]  next_vcount;
   logic [4:0]  ra;
   logic [31:0] rd_data;
   logic        draw_valid, draw_ready, draw_idle;
   logic [9:0]  col_base;
   logic        hflip;
   logic [7:0]  frame_id;
   logic [3:0]  row_off;
   logic        row_overflow;
   logic [7:0]  drop_count;
   logic        fe_done;

   sprite_line_scanner #(.NUM_SPRITE(NUM), .MAX_SLOT(8), .SPRITE_H(H), .V_ACTIVE(VACT)) dut (
      .clk(clk), .reset(reset), .start_row(start_row), .next_vcount(next_vcount),
      .ra(ra), .rd_data(rd_data), .draw_valid(draw_valid), .draw_ready(draw_ready),
      .draw_idle(draw_idle), .col_base(col_base), .hflip(hflip), .frame_id(frame_id),
      .row_off(row_off), .row_overflow(row_overflow), .drop_count(drop_count), .fe_done(fe_done)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [NUM];
   always @(posedge clk) rd_data <= mem[ra];

   typedef struct {int col; int hf; int frame; int roff;} exp_t;
   exp_t sb[$];

   int checks = 0, failures = 0;
   int xfers = 0, last_roff = -1;
   int ready_mode = 1, idle_mode = 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] spr(input bit en, input bit hf, input bit vf,
                                       input int y, input int x, input int fr);
      logic [31:0] w;
      w = '0;
      w[31] = en; w[30] = hf; w[29] = vf;
      w[26:18] = y[8:0]; w[17:8] = x[9:0]; w[7:0] = fr[7:0];
      return w;
   endfunction

   function automatic bit is_hit(input logic [31:0] w, input int vc);
      int y;
      y = int'(w[26:18]);
      return w[31] && vc < VACT && vc >= y && (vc - y) < H;
   endfunction

   // Expected transfers for a row: hits in index order, at most 'cap' of them captured.
   task automatic model_row(input int vc, input int cap, output int hits);
      exp_t e;
      hits = 0;
      for (int i = 0; i < NUM; i++) begin
         if (is_hit(mem[i], vc)) begin
            e.col = int'(mem[i][17:8]); e.hf = int'(mem[i][30]);
            e.frame = int'(mem[i][7:0]); e.roff = vc - int'(mem[i][26:18]);
`ifdef SPRITE_VFLIP_EN
            if (mem[i][29]) e.roff = H - 1 - e.roff;
`endif
            if (hits < cap) sb.push_back(e);
            hits++;
         end
      end
   endtask

   always @(negedge clk) begin
      if (!reset && draw_valid) begin
         if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_transfer: got col_base=%0d frame_id=%0d, expected none", col_base, frame_id);
         end else begin
            check("col_base", 32'(col_base), sb[0].col);
            check("hflip", 32'(hflip), sb[0].hf);
            check("frame_id", 32'(frame_id), sb[0].frame);
            check("row_off", 32'(row_off), sb[0].roff);
            if (draw_ready) begin
               last_roff = int'(row_off);
               xfers++;
               void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         draw_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(ready_mode);
         draw_idle  = (idle_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'(idle_mode);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic pulse_start(input int vc);
      @(posedge clk); #1;
      next_vcount = 10'(vc);
      start_row   = 1'b1;
      @(posedge clk); #1;
      start_row   = 1'b0;
   endtask

   // Cycle n of the loop is cycle T+n relative to the start_row cycle T.
   task automatic watch(input int max_cyc, input bit stop_on_fe, output int fe_cyc, output int dv_cyc);
      fe_cyc = -1; dv_cyc = -1;
      for (int n = 1; n <= max_cyc; n++) begin
         @(negedge clk);
         if (dv_cyc < 0 && draw_valid) dv_cyc = n;
         if (fe_done && fe_cyc < 0) begin
            fe_cyc = n;
            if (stop_on_fe) break;
         end
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < NUM; i++) mem[i] = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ra"}, 32'(ra), 0);
      check({tag, "_draw_valid"}, 32'(draw_valid), 0);
      check({tag, "_col_base"}, 32'(col_base), 0);
      check({tag, "_hflip"}, 32'(hflip), 0);
      check({tag, "_frame_id"}, 32'(frame_id), 0);
      check({tag, "_row_off"}, 32'(row_off), 0);
      check({tag, "_row_overflow"}, 32'(row_overflow), 0);
      check({tag, "_drop_count"}, 32'(drop_count), 0);
      check({tag, "_fe_done"}, 32'(fe_done), 1);
   endtask

   initial begin
      int fe, dv, hits, x0;
      int bvc [4] = '{99, 100, 115, 116};
      reset = 1'b1; start_row = 1'b0; next_vcount = '0;
      draw_ready = 1'b1; draw_idle = 1'b1;
      clear_mem();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1 reset = 1'b0;

      // Single sprite, drawer busy at first so fe_done must wait for draw_idle.
      clear_mem();
      mem[5] = spr(1, 1, 0, 100, 200, 7);
      idle_mode = 0;
      model_row(103, 9, hits);
      pulse_start(103);
      watch(40, 0, fe, dv);
      check("single_first_valid_cycle", dv, 9);
      check("single_fe_held_while_busy", fe, -1);
      check("single_transfers", xfers, 1);
      idle_mode = 1;
      watch(20, 1, fe, dv);
      check("single_fe_after_idle", 32'(fe > 0), 1);
      check("single_sb_empty", sb.size(), 0);
      check("single_overflow", 32'(row_overflow), 0);

      // All-miss visible row: fe_done at T+NUM+3.
      clear_mem();
      mem[2] = spr(1, 0, 0, 200, 1, 1);
      pulse_start(50);
      watch(100, 1, fe, dv);
      check("miss_fe_cycle", fe, NUM + 3);
      check("miss_no_valid", dv, -1);

      // Blank row from idle: fe_done in T+1.
      pulse_start(600);
      watch(5, 1, fe, dv);
      check("blank_fe_cycle", fe, 1);

      // Vertical boundaries of a sprite at y=100.
      clear_mem();
      mem[3] = spr(1, 0, 0, 100, 17, 33);
      foreach (bvc[b]) begin
         x0 = xfers;
         model_row(bvc[b], 9, hits);
         pulse_start(bvc[b]);
         watch(200, 1, fe, dv);
         check($sformatf("boundary_%0d_fe", bvc[b]), 32'(fe > 0), 1);
         check($sformatf("boundary_%0d_transfers", bvc[b]), xfers - x0,
               (bvc[b] == 100 || bvc[b] == 115) ? 1 : 0);
      end
      check("boundary_last_row_off", last_roff, 15);

      // Vertical flip bit.
      clear_mem();
      mem[5] = spr(1, 0, 1, 100, 200, 7);
      model_row(103, 9, hits);
      pulse_start(103);
      watch(200, 1, fe, dv);
`ifdef SPRITE_VFLIP_EN
      check("vflip_row_off", last_roff, 12);
`else
      check("vflip_row_off", last_roff, 3);
`endif

      // Overflow: 32 hits with a stalled drawer, 9 captured.
      for (int i = 0; i < NUM; i++) mem[i] = spr(1, i % 2, 0, 0, i * 3 + 5, i);
      ready_mode = 0;
      x0 = xfers;
      model_row(0, 9, hits);
      pulse_start(0);
      watch(45, 0, fe, dv);
      check("ovf_flag", 32'(row_overflow), 1);
      check("ovf_drop_count", 32'(drop_count), 23);
      check("ovf_valid_held", 32'(draw_valid), 1);
      ready_mode = 1;
      watch(100, 1, fe, dv);
      check("ovf_fe", 32'(fe > 0), 1);
      check("ovf_transfers", xfers - x0, 9);
      check("ovf_sb_empty", sb.size(), 0);

      // Blank start_row in the middle of DRAIN flushes everything.
      clear_mem();
      for (int i = 4; i < 7; i++) mem[i] = spr(1, 0, 0, 10, i * 10, i);
      ready_mode = 0;
      model_row(12, 9, hits);
      pulse_start(12);
      watch(40, 0, fe, dv);
      @(posedge clk); #1;
      next_vcount = 10'd480; start_row = 1'b1;
      @(posedge clk); #1;
      start_row = 1'b0;
      sb.delete();
      @(negedge clk);
      check("flush_valid", 32'(draw_valid), 0);
      check("flush_fe", 32'(fe_done), 1);
      ready_mode = 1;
      x0 = xfers;
      watch(10, 0, fe, dv);
      check("flush_no_transfers", xfers - x0, 0);

      // Randomized rows with backpressure; at most 8 hits so nothing drops.
      ready_mode = 2; idle_mode = 2;
      for (int r = 0; r < 25; r++) begin
         int vc, nh;
         vc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(480, 1023)) : int'($urandom_range(0, 479));
         nh = 0;
         for (int i = 0; i < NUM; i++) begin
            mem[i] = spr($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         (vc + 4 - int'($urandom_range(0, 24))) & 511,
                         int'($urandom_range(0, 1023)), int'($urandom_range(0, 255)));
            if (is_hit(mem[i], vc)) begin
               if (nh >= 8) mem[i][31] = 1'b0;
               else nh++;
            end
         end
         model_row(vc, 9, hits);
         pulse_start(vc);
         watch(3000, 1, fe, dv);
         check($sformatf("rand%0d_fe", r), 32'(fe > 0), 1);
         check($sformatf("rand%0d_sb_empty", r), sb.size(), 0);
         check($sformatf("rand%0d_drops", r), 32'(drop_count), 0);
      end

      // Asynchronous reset in the middle of an overflowing row.
      ready_mode = 0; idle_mode = 1;
      for (int i = 0; i < NUM; i++) mem[i] = spr(1, 1, 0, 0, i * 3 + 5, i + 1);
      model_row(0, 9, hits);
      pulse_start(0);
      watch(40, 0, fe, dv);
      check("pre_reset_overflow", 32'(row_overflow), 1);
      #2 reset = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      sb.delete();
      @(posedge clk); #1 reset = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
